midori_round_ctrl: RTL
======================

# midori_round_ctrl

Parametrised round/phase sequencer for the threshold-implemented Midori64 datapath. It replaces the fixed 5-bit cycle counter with a configurable number of rounds and cycles per round, and adds busy/done status, an abort path, and stalling on randomness availability. It sits beside the shared state and key pipelines and drives their load-select, enable, and round-index inputs.

## Interface
- ROUNDS, default 16: number of cipher rounds; must be ≥ 2.
- CYCLES_PER_ROUND, default 2: register stages per round (share pipeline depth); must be ≥ 1.
- ROUND_W, derived localparam, = max(1, clog2(ROUNDS)).
- PH_W, derived localparam, = max(1, clog2(CYCLES_PER_ROUND)).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new encryption; honoured only in IDLE or DONE.
- abort  in  1  synchronous cancel; returns the block to IDLE from any state.
- rng_valid  in  1  fresh masks available this cycle; low stalls the sequence.
- start_sel  out  1  datapath input-mux select (load plaintext/key shares).
- en  out  1  datapath register enable (advance strobe).
- round  out  ROUND_W  current round index.
- phase  out  PH_W  cycle index within the round.
- last_round  out  1  high when busy and round == ROUNDS-1.
- rng_req  out  1  mask request to the PRNG; equals busy.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (level).

## Operation
- States:
  - IDLE: after reset.
  - RUN: sequencing.
  - DONE: result valid, held until restarted or aborted.
- start_sel = start & ~busy & ~abort (combinational); the datapath loads on this cycle.
- IDLE/DONE + start & ~abort:
  - Next state RUN, round = 0, phase = 0.
  - done drops on the same edge.
- RUN, advance (rng_valid = 1):
  - Phase increments.
  - If phase == CYCLES_PER_ROUND-1: phase wraps to 0 and round increments.
  - If additionally round == ROUNDS-1: next state DONE; round and phase hold their final values (ROUNDS-1, CYCLES_PER_ROUND-1).
- RUN, stall (rng_valid = 0): round and phase hold; en = 0.
- en = busy & rng_valid.
- start during RUN is ignored; there are no side effects.
- abort has priority over start and over advance:
  - Next state IDLE, round = 0, phase = 0, done = 0.
  - start_sel is forced to 0 in that cycle.
- CYCLES_PER_ROUND = 1: phase is constantly 0 and round advances on every en.
- Counters must never exceed ROUNDS-1 or CYCLES_PER_ROUND-1 (non-power-of-two values are supported).
- Reset (asynchronous, any time, including mid-run):
  - State IDLE, round = 0, phase = 0.
  - busy, done, en, rng_req, last_round are all 0.
  - start_sel follows start combinationally.

## Timing
- Cycle 0: start = 1 in IDLE, so start_sel = 1.
- Cycle 1: busy = 1, round = 0, phase = 0, en = rng_valid.
- With rng_valid held high:
  - RUN lasts exactly ROUNDS*CYCLES_PER_ROUND cycles.
  - done rises at cycle ROUNDS*CYCLES_PER_ROUND + 1 (cycle 33 for 16×2).
- Each cycle of rng_valid = 0 in RUN delays done by exactly one cycle.
- last_round is high for the final CYCLES_PER_ROUND advancing cycles plus any stalls within them.
- Back-to-back operation: start in a DONE cycle gives busy = 1 on the next cycle; there is no idle gap.
- All outputs except start_sel are registered or decoded from registered state; no combinational path from rng_valid to any output except en.

## Test plan
- Reset: assert rst mid-RUN (round = 7) → asynchronously round = 0, phase = 0, busy = 0, done = 0, en = 0.
- Nominal (16×2, rng_valid = 1): pulse start → busy for 32 cycles; round steps 0..15 every 2 cycles; done = 1 from cycle 33 and held.
- Stalls: rng_valid low for 5 cycles at round 3, phase 1 → round and phase frozen, en = 0 for those cycles; done arrives at cycle 38.
- Ignored start and abort priority:
  - start at round 9 → no change.
  - abort + start together at round 12 → IDLE next cycle, start_sel = 0, done never asserted.
- Restart: start while in DONE → done falls and busy rises next cycle; round = 0, phase = 0.
- Parametrisation: ROUNDS = 12, CYCLES_PER_ROUND = 3 and ROUNDS = 16, CYCLES_PER_ROUND = 1 → done at cycle 37 and 17 respectively; phase never exceeds 2 and 0 respectively.

Source files
------------

// File: rtl/midori_round_ctrl.sv
// -----------------------------------------------------------------------------
// midori_round_ctrl
//
// Round/phase sequencer for the threshold-implemented Midori64 datapath.
// Steps a round counter and a within-round phase counter, advancing only on
// cycles where fresh masks are available, and reports busy/done status.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   request a new encryption (honoured in IDLE or DONE)
//   abort      in   synchronous cancel back to IDLE, beats start and advance
//   rng_valid  in   masks available this cycle; low stalls the sequence
//   start_sel  out  datapath input-mux select (load plaintext/key shares)
//   en         out  datapath register enable (advance strobe)
//   round      out  current round index
//   phase      out  cycle index within the round
//   last_round out  busy and round == ROUNDS-1
//   rng_req    out  mask request to the PRNG (same as busy)
//   busy       out  high while sequencing
//   done       out  high (level) once the final round has completed
// -----------------------------------------------------------------------------
module midori_round_ctrl #(
  parameter  int ROUNDS           = 16,
  parameter  int CYCLES_PER_ROUND = 2,
  localparam int ROUND_W          = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
  localparam int PH_W             = (CYCLES_PER_ROUND > 1) ? $clog2(CYCLES_PER_ROUND) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               rng_valid,
  output logic               start_sel,
  output logic               en,
  output logic [ROUND_W-1:0] round,
  output logic [PH_W-1:0]    phase,
  output logic               last_round,
  output logic               rng_req,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Terminal counter values; compares against these keep both counters
  // inside their legal range for non-power-of-two parameters.
  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS - 1);
  localparam logic [PH_W-1:0]    PH_LAST    = PH_W'(CYCLES_PER_ROUND - 1);

  state_t             state_reg;
  logic [ROUND_W-1:0] round_reg;
  logic [PH_W-1:0]    phase_reg;
  logic               busy_reg;
  logic               done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      round_reg <= '0;
      phase_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (abort) begin
      state_reg <= ST_IDLE;
      round_reg <= '0;
      phase_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg <= ST_RUN;
            round_reg <= '0;
            phase_reg <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        ST_RUN: begin
          // start is deliberately ignored here; only rng_valid moves us on.
          if (rng_valid) begin
            if (phase_reg == PH_LAST) begin
              if (round_reg == ROUND_LAST) begin
                // Final advance: counters hold their terminal values so the
                // datapath side can still see which round produced the result.
                state_reg <= ST_DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end else begin
                phase_reg <= '0;
                round_reg <= round_reg + ROUND_W'(1);
              end
            end else begin
              phase_reg <= phase_reg + PH_W'(1);
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          round_reg <= '0;
          phase_reg <= '0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  // start_sel is the only output with a combinational path from inputs other
  // than en; it lets the datapath load shares on the same cycle start is seen.
  assign start_sel  = start & ~busy_reg & ~abort;
  assign en         = busy_reg & rng_valid;
  assign round      = round_reg;
  assign phase      = phase_reg;
  assign last_round = busy_reg & (round_reg == ROUND_LAST);
  assign rng_req    = busy_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule
